// File: rtl/gpu_cmd_scheduler.sv
// gpu_cmd_scheduler: queues 32-bit instructions and dispatches each to one execution unit at a time,
// with host back-pressure, a per-command watchdog and a sticky first-error report.
module gpu_cmd_scheduler #(
   parameter int NUM_UNITS  = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 1023
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [31:0]          i_instr,
   input  logic                 i_instr_valid,
   output logic                 o_instr_ready,
   output logic [NUM_UNITS-1:0] o_unit_start,
   output logic [NUM_UNITS-1:0] o_unit_abort,
   output logic [23:0]          o_unit_args,
   input  logic [NUM_UNITS-1:0] i_unit_done,
   output logic                 o_busy,
   output logic                 o_error,
   output logic [1:0]           o_err_code,
   input  logic                 i_err_clear
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int IW = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1;
   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t               state_q, state_d;
   logic [31:0]          mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_q, rd_q;
   logic [AW:0]          cnt_q;
   logic [IW-1:0]        idx_q, idx_d;
   logic [23:0]          args_q, args_d;
   logic [WW-1:0]        wd_q, wd_d;
   logic [NUM_UNITS-1:0] start_q, start_d;
   logic                 err_q, err_d;
   logic [1:0]           code_q, code_d, new_code;
   logic                 push, pop, legal, done, expire;
   logic [7:0]           op;

   assign o_instr_ready = !i_reset && cnt_q != (AW+1)'(FIFO_DEPTH);
   assign push          = i_instr_valid && o_instr_ready;
   assign pop           = state_q == IDLE && cnt_q != '0;
   assign op            = mem_q[rd_q][7:0];
   assign legal         = op != 8'd0 && op <= 8'(NUM_UNITS);
   // the start-pulse cycle is the one with the watchdog still at 0, so done is ignored there
   assign done          = state_q == WAIT && wd_q != '0 && i_unit_done[idx_q];
   assign expire        = state_q == WAIT && wd_q == WW'(TIMEOUT) && !done;

   assign o_unit_start  = start_q;
   assign o_unit_abort  = expire ? NUM_UNITS'(1) << idx_q : '0;
   assign o_unit_args   = args_q;
   assign o_busy        = cnt_q != '0 || state_q != IDLE;
   assign o_error       = err_q;
   assign o_err_code    = code_q;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      args_d   = args_q;
      wd_d     = wd_q;
      start_d  = '0;
      new_code = 2'd0;
      if (pop && legal) begin
         state_d = WAIT;
         idx_d   = IW'(op - 8'd1);
         args_d  = mem_q[rd_q][31:8];
         wd_d    = '0;
         start_d = NUM_UNITS'(1) << IW'(op - 8'd1);
      end else if (pop && op != 8'd0) begin
         new_code = 2'd1;
      end
      if (state_q == WAIT) begin
         wd_d    = wd_q + 1'b1;
         state_d = (done || expire) ? IDLE : WAIT;
         new_code = expire ? 2'd2 : new_code;
      end
      // a clear in the same cycle as a new error still lets the new error land
      err_d  = err_q && !i_err_clear;
      code_d = err_d ? code_q : 2'd0;
      if (new_code != 2'd0 && !err_d) begin
         err_d  = 1'b1;
         code_d = new_code;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= IDLE;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         args_q  <= '0;
         wd_q    <= '0;
         start_q <= '0;
         err_q   <= 1'b0;
         code_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_q + AW'(push);
         rd_q    <= rd_q + AW'(pop);
         cnt_q   <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
         idx_q   <= idx_d;
         args_q  <= args_d;
         wd_q    <= wd_d;
         start_q <= start_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) mem_q[wr_q] <= i_instr;
   end
endmodule

// File: tb/tb_gpu_cmd_scheduler.sv
// tb_gpu_cmd_scheduler: scenario tasks plus a randomized run checked against a
// stream-order model of dispatches, aborts and the first error.
module tb_gpu_cmd_scheduler;
   localparam int NU = 4;
   localparam int TO = 16;

   typedef struct { int unit; logic [3:0] vec; logic [23:0] args; int cyc; } disp_t;
   typedef struct { int unit; int age; int cyc; } abort_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        valid;
   logic        ready;
   logic [3:0]  start, abort, unit_done, resp_done, extra_done;
   logic [23:0] args;
   logic        busy, error, err_clear;
   logic [1:0]  err_code;

   int     checks = 0, failures = 0, cyc = 0, last_push_cyc = 0;
   int     act = -1, age = 0, cur_dly = 0;
   logic   m_err = 1'b0;
   logic [1:0] m_code = 2'd0;
   disp_t  exp_q[$], obs_q[$];
   abort_t obs_ab[$];
   int     exp_ab[$], dly_q[$];

   assign unit_done = resp_done | extra_done;

   gpu_cmd_scheduler #(.NUM_UNITS(NU), .FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_reset(rst), .i_instr(instr), .i_instr_valid(valid),
      .o_instr_ready(ready), .o_unit_start(start), .o_unit_abort(abort),
      .o_unit_args(args), .i_unit_done(unit_done), .o_busy(busy),
      .o_error(error), .o_err_code(err_code), .i_err_clear(err_clear)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1);
   end

   function automatic int oh_idx(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   // advance one cycle: drive the unit responder at negedge, then sample outputs
   task automatic tick();
      disp_t d;
      abort_t a;
      @(negedge clk);
      cyc++;
      if (act >= 0) age++;
      resp_done = (act >= 0 && age == cur_dly) ? 4'(1 << act) : 4'b0;
      #1;
      if (resp_done != 4'b0) act = -1;
      if (abort != 4'b0) begin
         a.unit = oh_idx(abort); a.age = age; a.cyc = cyc;
         obs_ab.push_back(a);
         act = -1;
      end
      if (start != 4'b0) begin
         d.unit = oh_idx(start); d.vec = start; d.args = args; d.cyc = cyc;
         obs_q.push_back(d);
         act = d.unit; age = 0;
         cur_dly = (dly_q.size() != 0) ? dly_q.pop_front() : 1;
      end
   endtask

   task automatic flush_model();
      exp_q.delete(); obs_q.delete(); obs_ab.delete(); exp_ab.delete();
   endtask

   task automatic push_instr(input logic [31:0] ins, input int dly);
      int n;
      disp_t d;
      logic [7:0] op;
      op = ins[7:0];
      n = 0;
      while (!ready && n < 200) begin tick(); n++; end
      checks++;
      if (ready !== 1'b1) begin failures++; $display("FAIL push_wait ready=%b required 1", ready); end
      instr = ins; valid = 1'b1; last_push_cyc = cyc;
      if (op >= 8'd1 && op <= 8'(NU)) begin
         d.unit = int'(op) - 1; d.vec = 4'(1 << d.unit); d.args = ins[31:8]; d.cyc = 0;
         exp_q.push_back(d);
         dly_q.push_back(dly);
         if (dly > TO) begin
            exp_ab.push_back(d.unit);
            if (!m_err) begin m_err = 1'b1; m_code = 2'd2; end
         end
      end else if (op != 8'd0 && !m_err) begin
         m_err = 1'b1; m_code = 2'd1;
      end
      tick();
      valid = 1'b0;
   endtask

   task automatic wait_idle(input int maxc);
      int n;
      n = 0;
      while ((busy || act >= 0) && n < maxc) begin tick(); n++; end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL wait_idle busy=%b required 0", busy); end
   endtask

   task automatic test_reset();
      @(negedge clk); #1;
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", ready); end
      checks++; if ({start, abort} !== 8'h0) begin failures++; $display("FAIL rst_pulses got=%h exp=0", {start, abort}); end
      checks++; if (args !== 24'h0) begin failures++; $display("FAIL rst_args got=%h exp=0", args); end
      checks++; if ({busy, error, err_code} !== 4'h0) begin failures++; $display("FAIL rst_status got=%h exp=0", {busy, error, err_code}); end
      rst = 1'b0;
      tick();
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", ready); end
   endtask

   task automatic test_basic();
      int t;
      flush_model();
      push_instr(32'h0012_3401, 3);
      t = last_push_cyc;
      checks++; if ({start, busy} !== 5'b0000_1) begin failures++; $display("FAIL basic_pop_cycle start/busy=%b exp=00001", {start, busy}); end
      tick();
      checks++; if (start !== 4'b0001 || cyc != t + 2) begin failures++; $display("FAIL basic_start got=%b cyc=%0d exp=0001 cyc=%0d", start, cyc, t + 2); end
      checks++; if (args !== 24'h001234) begin failures++; $display("FAIL basic_args got=%h exp=001234", args); end
      tick();
      checks++; if (start !== 4'b0 || args !== 24'h001234) begin failures++; $display("FAIL basic_pulse_len start=%b args=%h exp=0000 001234", start, args); end
      tick(); tick();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_at_done got=%b exp=1", busy); end
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_fall got=%b exp=0", busy); end
   endtask

   task automatic test_back_to_back();
      int n, s;
      flush_model();
      for (int k = 0; k < 5; k++) push_instr({24'($urandom), 8'h02}, k == 0 ? 10 : 2);
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL b2b_full ready=%b exp=0", ready); end
      n = 0;
      while (!ready && n < 50) begin tick(); n++; end
      s = (obs_q.size() != 0) ? obs_q[0].cyc : -100;
      checks++; if (ready !== 1'b1 || cyc != s + 12) begin failures++; $display("FAIL b2b_ready_rise ready=%b cyc=%0d exp=1 cyc=%0d", ready, cyc, s + 12); end
      wait_idle(200);
      checks++; if (obs_q.size() != 5) begin failures++; $display("FAIL b2b_count got=%0d exp=5", obs_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= obs_q.size() || obs_q[i].vec !== exp_q[i].vec || obs_q[i].args !== exp_q[i].args) begin
            failures++; $display("FAIL b2b_order idx=%0d got=%b/%h exp=%b/%h", i,
               i < obs_q.size() ? obs_q[i].vec : 4'hx, i < obs_q.size() ? obs_q[i].args : 24'hx, exp_q[i].vec, exp_q[i].args);
         end
      end
   endtask

   task automatic test_illegal();
      flush_model();
      push_instr(32'h0000_0007, 0);
      push_instr(32'h00AB_CD02, 2);
      wait_idle(50);
      checks++; if ({error, err_code} !== {m_err, m_code}) begin failures++; $display("FAIL illegal_err got=%b/%0d exp=%b/%0d", error, err_code, m_err, m_code); end
      checks++; if (obs_q.size() != 1 || obs_q[0].vec !== 4'b0010 || obs_q[0].args !== 24'h00ABCD) begin failures++; $display("FAIL illegal_next_start n=%0d exp one start[1] args 00abcd", obs_q.size()); end
      err_clear = 1'b1; tick(); err_clear = 1'b0; tick();
      m_err = 1'b0; m_code = 2'd0;
      checks++; if ({error, err_code} !== 3'b000) begin failures++; $display("FAIL illegal_clear got=%b/%0d exp=0/0", error, err_code); end
   endtask

   task automatic test_timeout();
      flush_model();
      push_instr(32'h0011_1103, 1000);
      push_instr(32'h0022_2201, 2);
      wait_idle(100);
      checks++; if (obs_ab.size() != 1 || obs_ab[0].unit != 2 || obs_ab[0].age != TO) begin failures++; $display("FAIL to_abort n=%0d unit=%0d age=%0d exp 1/2/%0d", obs_ab.size(), obs_ab.size() ? obs_ab[0].unit : -1, obs_ab.size() ? obs_ab[0].age : -1, TO); end
      checks++; if ({error, err_code} !== {m_err, m_code}) begin failures++; $display("FAIL to_err got=%b/%0d exp=%b/%0d", error, err_code, m_err, m_code); end
      checks++; if (obs_q.size() != 2 || obs_ab.size() != 1 || obs_q[1].unit != 0 || obs_q[1].cyc != obs_ab[0].cyc + 2) begin failures++; $display("FAIL to_next_dispatch n=%0d exp start[0] two cycles after abort", obs_q.size()); end
      // clear coinciding with a new illegal-opcode error: the new code replaces the old one
      push_instr(32'h0000_0009, 0);
      err_clear = 1'b1; tick(); err_clear = 1'b0; tick();
      m_err = 1'b1; m_code = 2'd1;
      checks++; if ({error, err_code} !== {m_err, m_code}) begin failures++; $display("FAIL clear_vs_new got=%b/%0d exp=%b/%0d", error, err_code, m_err, m_code); end
   endtask

   task automatic test_done_filter();
      int n, s;
      flush_model();
      push_instr(32'h0055_5501, 6);
      n = 0;
      while (obs_q.size() == 0 && n < 10) begin tick(); n++; end
      s = (obs_q.size() != 0) ? obs_q[0].cyc : -100;
      extra_done = 4'b1001;
      tick(); extra_done = 4'b1000;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL filter_startcycle_done busy=%b exp=1", busy); end
      tick();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL filter_other_unit busy=%b exp=1", busy); end
      tick(); extra_done = 4'b0;
      n = 0;
      while (busy && n < 20) begin tick(); n++; end
      checks++; if (busy !== 1'b0 || cyc != s + 7) begin failures++; $display("FAIL filter_done_cycle busy=%b cyc=%0d exp=0 cyc=%0d", busy, cyc, s + 7); end
      checks++; if (obs_ab.size() != 0) begin failures++; $display("FAIL filter_abort n=%0d exp=0", obs_ab.size()); end
   endtask

   task automatic test_reset_mid();
      flush_model();
      for (int k = 0; k < 4; k++) push_instr({24'h00A000 + 24'(k), 8'h01}, 1000);
      tick();
      rst = 1'b1; #1;
      checks++; if ({start, abort, args} !== 32'h0) begin failures++; $display("FAIL midrst_unit_outs got=%h exp=0", {start, abort, args}); end
      checks++; if ({ready, busy, error, err_code} !== 5'h0) begin failures++; $display("FAIL midrst_status got=%b exp=00000", {ready, busy, error, err_code}); end
      tick(); tick();
      rst = 1'b0;
      act = -1; dly_q.delete(); flush_model();
      m_err = 1'b0; m_code = 2'd0;
      repeat (5) tick();
      checks++; if (busy !== 1'b0 || ready !== 1'b1 || obs_q.size() != 0) begin failures++; $display("FAIL midrst_after busy=%b ready=%b starts=%0d exp 0/1/0", busy, ready, obs_q.size()); end
   endtask

   task automatic test_random();
      int r, dly;
      logic [7:0] op;
      flush_model();
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) tick();
         r = $urandom_range(0, 19);
         op = (r < 3) ? 8'h00 : (r < 5) ? 8'($urandom_range(5, 255)) : 8'($urandom_range(1, NU));
         r = $urandom_range(0, 9);
         dly = (r < 6) ? $urandom_range(1, 8) : (r == 6) ? TO : (r == 7) ? TO - 1 : $urandom_range(TO + 1, TO + 9);
         push_instr({24'($urandom), op}, dly);
      end
      wait_idle(3000);
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rnd_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= obs_q.size() || obs_q[i].vec !== exp_q[i].vec || obs_q[i].args !== exp_q[i].args) begin
            failures++; $display("FAIL rnd_dispatch idx=%0d got=%b/%h exp=%b/%h", i,
               i < obs_q.size() ? obs_q[i].vec : 4'hx, i < obs_q.size() ? obs_q[i].args : 24'hx, exp_q[i].vec, exp_q[i].args);
         end
      end
      checks++; if (obs_ab.size() != exp_ab.size()) begin failures++; $display("FAIL rnd_abort_count got=%0d exp=%0d", obs_ab.size(), exp_ab.size()); end
      for (int i = 0; i < exp_ab.size() && i < obs_ab.size(); i++) begin
         checks++;
         if (obs_ab[i].unit != exp_ab[i] || obs_ab[i].age != TO) begin
            failures++; $display("FAIL rnd_abort idx=%0d got=%0d@%0d exp=%0d@%0d", i, obs_ab[i].unit, obs_ab[i].age, exp_ab[i], TO);
         end
      end
      checks++; if ({error, err_code} !== {m_err, m_code}) begin failures++; $display("FAIL rnd_err got=%b/%0d exp=%b/%0d", error, err_code, m_err, m_code); end
   endtask

   initial begin
      rst = 1'b0; instr = '0; valid = 1'b0; err_clear = 1'b0;
      resp_done = '0; extra_done = '0;
      #2 rst = 1'b1;
      test_reset();
      test_basic();
      test_back_to_back();
      test_illegal();
      test_timeout();
      test_done_filter();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
